// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the UART transmitter and receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam int DATA_WIDTH     = 8;
    localparam int OS_16_BCLK_CNT = 16;

    // bclk tick index at the centre of a bit period, counted from the bit's first tick
    function automatic int rx_mid_cnt(input int os_cnt);
        return os_cnt / 2 - 1;
    endfunction

    localparam int RX_MID_CNT = rx_mid_cnt(OS_16_BCLK_CNT);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_RECV,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: oversample tick, serial line and received-word outputs of the UART receiver.
// Latency: n/a (wires only).
// Backpressure: none; the receiver side (master) cannot be stalled by the FIFO side.
interface uart_rx_if #(
    parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH
);
    logic                  bclk;
    logic                  rx;
    logic [DATA_WIDTH-1:0] dout;
    logic                  rx_done;
    logic                  frame_err;

    modport master (
        input  bclk,
        input  rx,
        output dout,
        output rx_done,
        output frame_err
    );

    modport slave (
        output bclk,
        output rx,
        input  dout,
        input  rx_done,
        input  frame_err
    );
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: SYNC_STAGES-deep flop chain bringing the asynchronous rx line into clk.
// Latency: SYNC_STAGES clk.
// Backpressure: none; samples every clk. Resets to the idle-high line level.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    // SYNC_STAGES must be at least 2 for metastability settling
    logic [SYNC_STAGES-1:0] chain;

    // shift the raw line through the chain; reset to 1 so no false falling edge follows reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= '1;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver (start, DATA_WIDTH bits LSB first, stop); UART_RX_MAJORITY_EN adds 2-of-3 sample voting.
// Latency: rx_done/frame_err/dout update 1 clk after the clk carrying the stop-bit sampling tick.
// Backpressure: none; rx_done is a write strobe and the consumer must accept every word.
module uart_rx #(
    parameter int DATA_WIDTH     = uart_pkg::DATA_WIDTH,
    parameter int OS_16_BCLK_CNT = uart_pkg::OS_16_BCLK_CNT,
    parameter int SYNC_STAGES    = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_rx_if.master bus
);
    import uart_pkg::*;

    localparam int                IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [3:0]        MID_CNT  = 4'(rx_mid_cnt(OS_16_BCLK_CNT));
    localparam logic [3:0]        LAST_CNT = 4'(OS_16_BCLK_CNT - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    rx_state_e             state;
    rx_state_e             state_nxt;
    logic                  rx_s;
    logic                  rx_prev;
    logic                  sample;
    logic [3:0]            bclk_cnt;
    logic [IDX_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  rx_done_q;
    logic                  frame_err_q;
    logic                  tick_mid;
    logic                  tick_end;
    logic                  cnt_clr;
    logic                  cnt_inc;
    logic                  idx_clr;
    logic                  idx_inc;
    logic                  shift_en;
    logic                  done_set;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.rx),
        .q     (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // the two ticks before the current one; with live rx_s this forms the 3-tick vote window
    logic [1:0] hist;

    // record rx_s on every oversample tick
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist <= 2'b11;
        end else if (bus.bclk) begin
            hist <= {hist[0], rx_s};
        end
    end

    assign sample = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    assign sample = rx_s;
`endif

    assign tick_mid = bus.bclk && (bclk_cnt == MID_CNT);
    assign tick_end = bus.bclk && (bclk_cnt == LAST_CNT);

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state: only a genuine high-to-low transition of rx_s can open a frame
    always_comb begin
        state_nxt = state;
        case (state)
            RX_IDLE:  if (rx_prev && !rx_s)                     state_nxt = RX_START;
            RX_START: if (tick_mid)                             state_nxt = sample ? RX_IDLE : RX_RECV;
            RX_RECV:  if (tick_end && (bit_idx == LAST_IDX))    state_nxt = RX_STOP;
            RX_STOP:  if (tick_end)                             state_nxt = RX_IDLE;
            default:                                            state_nxt = RX_IDLE;
        endcase
    end

    // per-state datapath controls
    always_comb begin
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        idx_clr  = 1'b0;
        idx_inc  = 1'b0;
        shift_en = 1'b0;
        done_set = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_clr = 1'b1;
            end
            RX_START: begin
                if (tick_mid) begin
                    cnt_clr = 1'b1;
                    idx_clr = 1'b1;
                end else if (bus.bclk) begin
                    cnt_inc = 1'b1;
                end
            end
            RX_RECV: begin
                if (tick_end) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    idx_inc  = (bit_idx != LAST_IDX);
                end else if (bus.bclk) begin
                    cnt_inc = 1'b1;
                end
            end
            RX_STOP: begin
                if (tick_end) begin
                    cnt_clr  = 1'b1;
                    done_set = 1'b1;
                end else if (bus.bclk) begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                cnt_clr = 1'b1;
            end
        endcase
    end

    // counters, shift register and registered outputs; dout updates even on a bad stop bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_prev     <= 1'b1;
            bclk_cnt    <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            dout_q      <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_prev <= rx_s;
            if (cnt_clr) begin
                bclk_cnt <= '0;
            end else if (cnt_inc) begin
                bclk_cnt <= bclk_cnt + 4'd1;
            end
            if (idx_clr) begin
                bit_idx <= '0;
            end else if (idx_inc) begin
                bit_idx <= bit_idx + IDX_W'(1);
            end
            if (shift_en) begin
                shreg <= {sample, shreg[DATA_WIDTH-1:1]};
            end
            rx_done_q   <= done_set;
            frame_err_q <= done_set & ~sample;
            if (done_set) begin
                dout_q <= shreg;
            end
        end
    end

    assign bus.dout      = dout_q;
    assign bus.rx_done   = rx_done_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random frames on the serial line, checked against a frame-level expectation model.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int DW = 8;
    localparam int FRAME_TICKS = 16 * (DW + 2);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mon_en = 1'b0;

    uart_rx_if #(.DATA_WIDTH(DW)) bus ();

    uart_rx #(
        .DATA_WIDTH     (DW),
        .OS_16_BCLK_CNT (16),
        .SYNC_STAGES    (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int stray_err = 0;
    time stop_t = 0;

    logic [DW-1:0] got_d[$];
    logic          got_e[$];
    time           got_t[$];
    logic [DW-1:0] exp_d[$];
    logic          exp_e[$];

    // bclk: one clk high out of every four, changing on the falling edge
    initial begin
        int div;
        div = 0;
        bus.bclk = 1'b0;
        forever begin
            @(negedge clk);
            div = (div + 1) % 4;
            bus.bclk = (div == 0);
        end
    end

    // capture every rx_done pulse with its data, error flag and time
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bus.rx_done === 1'b1) begin
                    got_d.push_back(bus.dout);
                    got_e.push_back(bus.frame_err);
                    got_t.push_back($time);
                end else if (bus.frame_err !== 1'b0) begin
                    stray_err++;
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete (n_chk=%0d)", n_chk);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick();
        @(posedge clk);
        while (bus.bclk !== 1'b1) @(posedge clk);
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) wait_tick();
    endtask

    // expected word: a single-tick glitch at a bit's centre corrupts that bit unless voting is on
    task automatic expect_frame(input logic [DW-1:0] d, input logic stop_bit, input int glitch_bit);
        logic [DW-1:0] w;
        w = d;
`ifndef UART_RX_MAJORITY_EN
        if (glitch_bit >= 0) w[glitch_bit] = ~w[glitch_bit];
`endif
        exp_d.push_back(w);
        exp_e.push_back(~stop_bit);
    endtask

    // line waveform: bit n of the frame occupies ticks 16n..16n+15 after the falling edge
    task automatic send_frame(input logic [DW-1:0] d, input logic stop_bit,
                              input int glitch_bit, input int rst_tick);
        logic v;
        wait_tick();
        #2 bus.rx = 1'b0;
        for (int t = 1; t < FRAME_TICKS; t++) begin
            wait_tick();
            if (t == 16 * DW + 24) stop_t = $time;
            #2;
            if (t == rst_tick) begin
                rst_n = 1'b0;
                bus.rx = 1'b1;
                @(posedge clk);
                #2 rst_n = 1'b1;
                return;
            end
            if (t < 16)                 v = 1'b0;
            else if (t < 16 * (DW + 1)) v = d[t / 16 - 1];
            else                        v = stop_bit;
            if (glitch_bit >= 0 && t == 23 + 16 * glitch_bit) v = ~v;
            bus.rx = v;
        end
    endtask

    task automatic check_frames(input string tag);
        check({tag, "_count"}, 32'(got_d.size()), 32'(exp_d.size()));
        while (got_d.size() > 0 && exp_d.size() > 0) begin
            check({tag, "_dout"}, 32'(got_d.pop_front()), 32'(exp_d.pop_front()));
            check({tag, "_ferr"}, 32'(got_e.pop_front()), 32'(exp_e.pop_front()));
            void'(got_t.pop_front());
        end
        got_d.delete();
        got_e.delete();
        got_t.delete();
        exp_d.delete();
        exp_e.delete();
    endtask

    initial begin
        logic [DW-1:0] d;
        logic          sb;
        int            gap;
        int            gl;

        bus.rx = 1'b1;
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_dout", 32'(bus.dout), 32'h0);
        check("rst_rx_done", 32'(bus.rx_done), 32'h0);
        check("rst_frame_err", 32'(bus.frame_err), 32'h0);
        check("rst_state", 32'(dut.state), 32'(RX_IDLE));
        rst_n = 1'b1;
        mon_en = 1'b1;
        wait_ticks(4);

        // clean frame and output latency
        send_frame(8'hA5, 1'b1, -1, -1);
        expect_frame(8'hA5, 1'b1, -1);
        wait_ticks(4);
        check("t1_latency", (got_t.size() > 0) ? 32'(got_t[0] - stop_t) : 32'hFFFF_FFFF, 32'd5);
        check_frames("t1");

        // short low pulse is rejected as a false start
        wait_tick();
        #2 bus.rx = 1'b0;
        wait_ticks(4);
        #2 bus.rx = 1'b1;
        wait_ticks(12);
        check("t2_state", 32'(dut.state), 32'(RX_IDLE));
        check("t2_nopulse", 32'(got_d.size()), 32'h0);
        send_frame(8'h5A, 1'b1, -1, -1);
        expect_frame(8'h5A, 1'b1, -1);
        wait_ticks(4);
        check_frames("t2");

        // bad stop bit, line held low afterwards
        send_frame(8'h3C, 1'b0, -1, -1);
        expect_frame(8'h3C, 1'b0, -1);
        wait_ticks(40);
        #2 bus.rx = 1'b1;
        wait_ticks(30);
        check_frames("t3");

        // back-to-back frames
        send_frame(8'h00, 1'b1, -1, -1);
        send_frame(8'hFF, 1'b1, -1, -1);
        expect_frame(8'h00, 1'b1, -1);
        expect_frame(8'hFF, 1'b1, -1);
        wait_ticks(4);
        check_frames("t4");

        // reset during data bit 3
        send_frame(8'hC3, 1'b1, -1, 16 * 4 + 8);
        @(negedge clk);
        check("t5_rst_dout", 32'(bus.dout), 32'h0);
        check("t5_rst_rx_done", 32'(bus.rx_done), 32'h0);
        check("t5_rst_frame_err", 32'(bus.frame_err), 32'h0);
        wait_ticks(FRAME_TICKS);
        check("t5_nopulse", 32'(got_d.size()), 32'h0);
        send_frame(8'h81, 1'b1, -1, -1);
        expect_frame(8'h81, 1'b1, -1);
        wait_ticks(4);
        check_frames("t5");

        // single-tick glitch at the bit-2 sampling point
        send_frame(8'h55, 1'b1, 2, -1);
        expect_frame(8'h55, 1'b1, 2);
        wait_ticks(4);
        check_frames("t6");

        // random frames, stop bits, glitches and idle gaps
        for (int i = 0; i < 20; i++) begin
            d   = DW'($urandom);
            sb  = ($urandom_range(0, 3) != 0);
            gl  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DW - 1)) : -1;
            gap = sb ? int'($urandom_range(0, 6)) : int'($urandom_range(1, 6));
            send_frame(d, sb, gl, -1);
            expect_frame(d, sb, gl);
            bus.rx = 1'b1;
            wait_ticks(gap);
            check_frames("rand");
        end

        wait_ticks(20);
        check("no_stray_ferr", 32'(stray_err), 32'h0);
        check("no_extra_frames", 32'(got_d.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
